// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch-stage sequencer: FSM encodings,
// PC-source selection, exception codes and well-known PC vectors.
package fetch_ctrl_pkg;

    // FSM state encodings
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // Exception code raised for a misaligned instruction fetch
    localparam logic [4:0] EXC_ADEL = 5'h04;

    // PC vectors used by the PC block
    localparam logic [31:0] RESET_PC     = 32'hBFC00000;
    localparam logic [31:0] EXC_VEC_BASE = 32'hBFC00380;

    // Next-PC source chosen for the PC block, in priority order
    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_ERET   = 2'd2,
        SEL_EXC    = 2'd3
    } pc_sel_e;

    // A fetch address must be word aligned
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: issues one bus request per PC value, holds the
// returned instruction until decode accepts it, steers the PC block's
// redirect selects and discards fetches made stale by a flush.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VEC  = 32'hBFC00380,
    parameter logic [31:0] NOP_INST = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_reg,
    output logic        pc_reg_enable,
    output logic        is_exception,
    output logic        is_excep_return,
    output logic        is_jump_branch,
    output logic [31:0] jump_branch_address,
    output logic [31:0] excep_return_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        id_stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_flush,
    input  logic        eret_flush,
    input  logic [31:0] epc,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_adel
);

    // The PC block owns the exception vector; kept here for reference only.
    logic unused_exc_vec;
    assign unused_exc_vec = ^EXC_VEC;

    logic [1:0]  state_reg, state_next;
    logic        drop_reg, drop_next;
    logic        br_pend_reg, br_pend_next;
    logic [31:0] br_target_reg, br_target_next;
    logic [31:0] inst_buf_reg;
    logic [31:0] if_pc_reg;
    logic        if_adel_reg;

    logic    flush;
    logic    misaligned;
    logic    in_req, in_wait, in_hold;
    logic    advance;
    logic    req_raw;
    logic    accept;
    logic    load_data;
    logic    load_adel;
    pc_sel_e pc_sel;

    assign flush      = exc_flush | eret_flush;
    assign misaligned = pc_misaligned(pc_reg);
    assign in_req     = (state_reg == S_REQ);
    assign in_wait    = (state_reg == S_WAIT);
    assign in_hold    = (state_reg == S_HOLD);
    assign advance    = in_hold && !id_stall && !flush;
    assign req_raw    = in_req && !misaligned;
    assign accept     = req_raw && inst_addr_ok;
    // A flush in the same cycle as returning data discards that data
    assign load_data  = in_wait && inst_data_ok && !drop_reg && !flush;
    assign load_adel  = in_req && misaligned && !flush;

    // Next-PC source priority: exception > ERET > branch > sequential
    always_comb begin
        pc_sel = SEL_SEQ;
        if (exc_flush) begin
            pc_sel = SEL_EXC;
        end else if (eret_flush) begin
            pc_sel = SEL_ERET;
        end else if (advance && (br_pend_reg || br_valid)) begin
            pc_sel = SEL_BRANCH;
        end
    end

    assign pc_reg_enable       = !rst && (flush || advance);
    assign is_exception        = !rst && (pc_sel == SEL_EXC);
    assign is_excep_return     = !rst && (pc_sel == SEL_ERET);
    assign is_jump_branch      = !rst && (pc_sel == SEL_BRANCH);
    assign jump_branch_address = rst ? 32'h0 : (br_valid ? br_target : br_target_reg);
    assign excep_return_pc     = rst ? 32'h0 : epc;
    assign inst_req            = !rst && req_raw;
    assign inst_addr           = rst ? 32'h0 : pc_reg;
    assign if_valid            = !rst && in_hold && !flush;
    assign if_inst             = inst_buf_reg;
    assign if_pc               = if_pc_reg;
    assign if_adel             = if_adel_reg;

    // FSM transitions, pending-branch tracking and in-flight drop marking
    always_comb begin
        state_next     = state_reg;
        drop_next      = drop_reg;
        br_pend_next   = br_pend_reg;
        br_target_next = br_target_reg;

        case (state_reg)
            S_REQ: begin
                if (misaligned) begin
                    state_next = S_HOLD;
                end else if (inst_addr_ok) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    drop_next  = 1'b0;
                    state_next = drop_reg ? S_REQ : S_HOLD;
                end
            end
            S_HOLD: begin
                if (!id_stall) begin
                    state_next   = S_REQ;
                    br_pend_next = 1'b0;
                end
            end
            default: state_next = S_REQ;
        endcase

        // A branch not consumed by an advance this cycle waits for the
        // delay slot to be delivered; the newest target wins.
        if (br_valid && !(in_hold && !id_stall)) begin
            br_pend_next   = 1'b1;
            br_target_next = br_target;
        end

        // Flush overrides everything; an accepted-but-unreturned fetch
        // must still be drained, so its data is marked for discard.
        if (flush) begin
            br_pend_next = 1'b0;
            if (in_wait && !inst_data_ok) begin
                drop_next  = 1'b1;
                state_next = S_WAIT;
            end else if (accept) begin
                drop_next  = 1'b1;
                state_next = S_WAIT;
            end else begin
                drop_next  = 1'b0;
                state_next = S_REQ;
            end
        end
    end

    // State registers plus the instruction/PC/address-error hold buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_REQ;
            drop_reg      <= 1'b0;
            br_pend_reg   <= 1'b0;
            br_target_reg <= 32'h0;
            inst_buf_reg  <= 32'h0;
            if_pc_reg     <= 32'h0;
            if_adel_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            drop_reg      <= drop_next;
            br_pend_reg   <= br_pend_next;
            br_target_reg <= br_target_next;
            if (accept) begin
                if_pc_reg <= pc_reg;
            end
            if (load_data) begin
                inst_buf_reg <= inst_rdata;
                if_adel_reg  <= 1'b0;
            end
            if (load_adel) begin
                inst_buf_reg <= NOP_INST;
                if_adel_reg  <= 1'b1;
                if_pc_reg    <= pc_reg;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a small PC-block model driving pc_reg.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc_reg;
    logic        pc_reg_enable;
    logic        is_exception;
    logic        is_excep_return;
    logic        is_jump_branch;
    logic [31:0] jump_branch_address;
    logic [31:0] excep_return_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        id_stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_flush;
    logic        eret_flush;
    logic [31:0] epc;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_adel;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .pc_reg              (pc_reg),
        .pc_reg_enable       (pc_reg_enable),
        .is_exception        (is_exception),
        .is_excep_return     (is_excep_return),
        .is_jump_branch      (is_jump_branch),
        .jump_branch_address (jump_branch_address),
        .excep_return_pc     (excep_return_pc),
        .inst_req            (inst_req),
        .inst_addr           (inst_addr),
        .inst_addr_ok        (inst_addr_ok),
        .inst_data_ok        (inst_data_ok),
        .inst_rdata          (inst_rdata),
        .id_stall            (id_stall),
        .br_valid            (br_valid),
        .br_target           (br_target),
        .exc_flush           (exc_flush),
        .eret_flush          (eret_flush),
        .epc                 (epc),
        .if_valid            (if_valid),
        .if_inst             (if_inst),
        .if_pc               (if_pc),
        .if_adel             (if_adel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PC block model: reset vector, then redirect or +4 on each enable
    always @(posedge clk) begin
        if (rst) begin
            pc_reg <= 32'hBFC00000;
        end else if (pc_reg_enable) begin
            if (is_exception)         pc_reg <= 32'hBFC00380;
            else if (is_excep_return) pc_reg <= excep_return_pc;
            else if (is_jump_branch)  pc_reg <= jump_branch_address;
            else                      pc_reg <= pc_reg + 32'd4;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            n_pass++;
            $display("check %s got=%h", tag, got);
        end
    endtask

    // One fetch: accept the request now, return data the next cycle.
    // Called at the start of an S_REQ cycle; returns at the start of S_HOLD.
    task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
        inst_addr_ok = 1'b1;
        #1;
        check({tag, "_req"}, inst_req, 1);
        check({tag, "_addr"}, inst_addr, addr);
        @(negedge clk);
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = data;
        #1;
        check({tag, "_noreq_wait"}, inst_req, 0);
        @(negedge clk);
        inst_data_ok = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
        id_stall = 1'b0; br_valid = 1'b0; br_target = 32'h0;
        exc_flush = 1'b0; eret_flush = 1'b0; epc = 32'h0;

        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_req", inst_req, 0);
        check("rst_valid", if_valid, 0);
        check("rst_pce", pc_reg_enable, 0);
        check("rst_inst", if_inst, 32'h0);
        check("rst_adel", if_adel, 0);

        // Sequential fetch: one cycle without addr_ok first
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("seq_req0", inst_req, 1);
        check("seq_addr0", inst_addr, 32'hBFC00000);
        @(negedge clk);
        do_fetch("seq0", 32'hBFC00000, 32'h11111111);
        #1;
        check("seq0_valid", if_valid, 1);
        check("seq0_pc", if_pc, 32'hBFC00000);
        check("seq0_inst", if_inst, 32'h11111111);
        check("seq0_pce", pc_reg_enable, 1);
        check("seq0_jb", is_jump_branch, 0);
        @(negedge clk);
        #1;
        check("seq_pce_once", pc_reg_enable, 0);
        @(negedge clk);
        do_fetch("seq1", 32'hBFC00004, 32'h22222222);
        #1;
        check("seq1_pc", if_pc, 32'hBFC00004);
        check("seq1_inst", if_inst, 32'h22222222);
        @(negedge clk);

        // Delay slot: branch arrives while 0xBFC00008 is in flight
        inst_addr_ok = 1'b1;
        #1;
        check("ds_addr", inst_addr, 32'hBFC00008);
        @(negedge clk);
        inst_addr_ok = 1'b0;
        br_valid = 1'b1; br_target = 32'hBFC00100;
        #1;
        check("ds_noreq", inst_req, 0);
        check("ds_jb_early", is_jump_branch, 0);
        @(negedge clk);
        br_valid = 1'b0; br_target = 32'h0;
        inst_data_ok = 1'b1; inst_rdata = 32'h33333333;
        #1;
        check("ds_jb_wait", is_jump_branch, 0);
        @(negedge clk);
        inst_data_ok = 1'b0;
        #1;
        check("ds_slot_pc", if_pc, 32'hBFC00008);
        check("ds_slot_inst", if_inst, 32'h33333333);
        check("ds_jb_adv", is_jump_branch, 1);
        check("ds_target", jump_branch_address, 32'hBFC00100);
        check("ds_pce", pc_reg_enable, 1);
        @(negedge clk);
        #1;
        check("ds_new_addr", inst_addr, 32'hBFC00100);
        check("ds_new_req", inst_req, 1);
        check("ds_jb_after", is_jump_branch, 0);

        // Flush in flight: exception while waiting, stale data two cycles later
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0;
        exc_flush = 1'b1;
        #1;
        check("fl_pce", pc_reg_enable, 1);
        check("fl_exc", is_exception, 1);
        check("fl_eret", is_excep_return, 0);
        check("fl_valid", if_valid, 0);
        @(negedge clk);
        exc_flush = 1'b0;
        #1;
        check("fl_noreq", inst_req, 0);
        check("fl_valid1", if_valid, 0);
        @(negedge clk);
        inst_data_ok = 1'b1; inst_rdata = 32'h12345678;
        #1;
        check("fl_valid2", if_valid, 0);
        @(negedge clk);
        inst_data_ok = 1'b0;
        #1;
        check("fl_valid3", if_valid, 0);
        check("fl_req", inst_req, 1);
        check("fl_vec", inst_addr, 32'hBFC00380);
        @(negedge clk);

        // Simultaneous exception + ERET + branch while holding
        do_fetch("sim", 32'hBFC00380, 32'h44444444);
        id_stall = 1'b1;
        #1;
        check("sim_hold_valid", if_valid, 1);
        check("sim_hold_pce", pc_reg_enable, 0);
        @(negedge clk);
        br_valid = 1'b1; br_target = 32'hDEAD0000;
        exc_flush = 1'b1; eret_flush = 1'b1; epc = 32'h80001000;
        #1;
        check("sim_exc", is_exception, 1);
        check("sim_eret", is_excep_return, 0);
        check("sim_jb", is_jump_branch, 0);
        check("sim_valid", if_valid, 0);
        check("sim_pce", pc_reg_enable, 1);
        @(negedge clk);
        br_valid = 1'b0; br_target = 32'h0;
        exc_flush = 1'b0; eret_flush = 1'b0; id_stall = 1'b0;
        #1;
        check("sim_addr", inst_addr, 32'hBFC00380);
        @(negedge clk);
        do_fetch("sim2", 32'hBFC00380, 32'h55555555);
        #1;
        check("sim_no_pend", is_jump_branch, 0);
        check("sim2_inst", if_inst, 32'h55555555);
        check("sim2_pce", pc_reg_enable, 1);
        @(negedge clk);

        // ERET redirect from S_REQ
        eret_flush = 1'b1;
        #1;
        check("eret_sel", is_excep_return, 1);
        check("eret_exc", is_exception, 0);
        check("eret_pce", pc_reg_enable, 1);
        check("eret_old_addr", inst_addr, 32'hBFC00384);
        @(negedge clk);
        eret_flush = 1'b0;
        #1;
        check("eret_addr", inst_addr, 32'h80001000);
        check("eret_req", inst_req, 1);
        @(negedge clk);

        // Stall held five cycles in S_HOLD
        do_fetch("stl", 32'h80001000, 32'h66666666);
        id_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stl_inst", if_inst, 32'h66666666);
            check("stl_pce", pc_reg_enable, 0);
            check("stl_valid", if_valid, 1);
            @(negedge clk);
        end
        // Release with a branch to a misaligned target
        id_stall = 1'b0;
        br_valid = 1'b1; br_target = 32'hBFC00002;
        #1;
        check("stl_rel_pce", pc_reg_enable, 1);
        check("stl_rel_jb", is_jump_branch, 1);
        @(negedge clk);
        br_valid = 1'b0; br_target = 32'h0;

        // Misaligned PC: no request, address error delivered with a NOP
        #1;
        check("mis_noreq", inst_req, 0);
        check("mis_pce", pc_reg_enable, 0);
        @(negedge clk);
        id_stall = 1'b1;
        #1;
        check("mis_valid", if_valid, 1);
        check("mis_adel", if_adel, 1);
        check("mis_inst", if_inst, 32'h0);
        check("mis_pc", if_pc, 32'hBFC00002);
        check("mis_noreq_hold", inst_req, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
